// File: rtl/uart_rx_fifo_periferico.sv
// UART 8N1 receiver with a byte FIFO, exposed as a memory-mapped peripheral.
// DATA/STATUS/CONTROL registers; irq_o is high while the FIFO holds data.
module uart_rx_fifo_periferico #(
  parameter int unsigned CLK_FREQ = 10_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        rx_i,
  input  logic        we_i,
  input  logic        re_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] dato_i,
  output logic [31:0] dato_o,
  output logic        irq_o
);

  localparam int unsigned CPB   = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W = $clog2(CPB) + 1;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       bit_idx, bit_next;
  logic [7:0]       shift, shift_next;
  logic             rx_meta, rxs;
  logic             push_req, set_ferr;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          empty, full, pop, push, set_ovr, ctrl_wr, flush, clr;
  logic          frame_err, overrun;
  logic          unused;

  assign unused = ^dato_i[31:2];

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt + 1'b1;
    bit_next   = bit_idx;
    shift_next = shift;
    push_req   = 1'b0;
    set_ferr   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (!rxs) state_next = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          cnt_next   = '0;
          bit_next   = '0;
          state_next = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == FULL_M1) begin
          cnt_next            = '0;
          shift_next[bit_idx] = rxs;
          bit_next            = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == FULL_M1) begin
          cnt_next   = '0;
          state_next = IDLE;
          if (rxs) push_req = 1'b1;
          else     set_ferr = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = re_i && (addr_i == 2'd0) && !empty;
  // Pop is resolved first, so a full FIFO still accepts a byte on a popping edge.
  assign push    = push_req && (!full || pop);
  assign set_ovr = push_req && full && !pop;
  assign ctrl_wr = we_i && (addr_i == 2'd2);
  assign flush   = ctrl_wr && dato_i[1];
  assign clr     = ctrl_wr && dato_i[0];

  always_ff @(posedge clk_i) begin
    if (!reset_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= set_ferr || (frame_err && !clr);
      overrun   <= set_ovr  || (overrun && !clr);
    end
  end

  assign irq_o = !empty;

  always_comb begin
    dato_o = '0;
    case (addr_i)
      2'd0: if (!empty) dato_o = {23'b0, 1'b1, mem[rd_ptr]};
      2'd1: begin
        dato_o[0]      = empty;
        dato_o[1]      = full;
        dato_o[2]      = frame_err;
        dato_o[3]      = overrun;
        dato_o[4 +: CW] = count;
      end
      default: dato_o = '0;
    endcase
  end

endmodule
